riscv_bp_ctrl: RTL and testbench
================================

RISCV_BP_CTRL -- requirements
Module: riscv_bp_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath/PC width.
REQ-002 SHALL have parameter BP_GLOBAL_BITS, default 2, global history bits in table index.
REQ-003 SHALL have parameter BP_LOCAL_BITS, default 8, PC bits in table index.
REQ-004 SHALL have parameter HAS_RVC, default 0; nonzero selects index PC bits from bit 1, else from bit 2.
REQ-005 SHALL have ports, one per line:
 clk  input  1  clock
 rstn  input  1  asynchronous active-low reset
 if_stall  input  1  hold lookup output
 if_pc  input  XLEN  lookup PC
 bp_predict  output  2  counter for if_pc, registered
 bp_ready  output  1  table initialised, predictions valid
 init_req  input  1  request full table re-initialisation
 bu_bp_update  input  1  update strobe from branch unit
 bu_bp_btaken  input  1  resolved outcome
 bu_bp_predict  input  2  counter value that travelled with the branch
 bu_bp_history  input  BP_GLOBAL_BITS  global history (lookup and update)
 bu_pc  input  XLEN  PC of resolving branch

Function
REQ-006 SHALL hold a table of 2^(BP_GLOBAL_BITS+BP_LOCAL_BITS) 2-bit saturating counters.
REQ-007 SHALL form index = {bu_bp_history, pc[BP_LOCAL_BITS+s-1:s]}, s=1 if HAS_RVC else 2; lookup uses if_pc, update uses bu_pc.
REQ-008 SHALL implement FSM states INIT and RUN; reset enters INIT with sweep counter 0.
REQ-009 In INIT SHALL write 2'b01 (weakly not-taken) to entry[sweep], increment sweep each cycle, ignore bu_bp_update, drive bp_predict=2'b00, bp_ready=0.
REQ-010 INIT SHALL transition to RUN the cycle after entry 2^(G+L)-1 is written; bp_ready rises in that same cycle edge (exactly 2^(G+L) cycles after reset release).
REQ-011 In RUN, init_req=1 SHALL return FSM to INIT with sweep=0 next cycle, bp_ready=0 next cycle; init_req during INIT restarts sweep at 0.
REQ-012 In RUN, bp_predict SHALL register table[lookup index] with 1-cycle latency when if_stall=0; if_stall=1 holds bp_predict.
REQ-013 On bu_bp_update=1 in RUN SHALL write new counter: btaken -> min(bu_bp_predict+1,3); not taken -> max(bu_bp_predict-1,0); no table read on update path.
REQ-014 Same-cycle update and lookup to equal index SHALL return the newly written counter (write-first forwarding).
REQ-015 Update and init_req in the same cycle: init_req wins, update dropped.
REQ-016 Index arithmetic SHALL ignore PC bits above index range (aliasing permitted); sweep counter width G+L+1 bits, no wrap beyond last entry.

Reset
REQ-017 rstn low SHALL asynchronously force state=INIT, sweep=0, bp_predict=2'b00, bp_ready=0.
REQ-018 Table contents SHALL NOT require reset; INIT sweep defines them. Reset mid-sweep restarts at 0.

Structure
REQ-019 FSM state enum and INIT counter value 2'b01 SHALL live in riscv_state_pkg; 2-bit counter constants in riscv_pkg.
REQ-020 Table SHALL be sub-module riscv_bp_ram (1 read + 1 write port, write-first), inferable as RAM.

Verification
REQ-021 Reset release, G=2,L=8 -> bp_ready rises after 1024 cycles; any lookup then returns 2'b01.
REQ-022 Update bu_pc=0x100, hist=2'b00, predict=2'b11, taken=1 -> entry stays 2'b11; predict=2'b01, taken=0 -> 2'b00.
REQ-023 Update and lookup same cycle, if_pc=bu_pc=0x204, hist=2'b10, predict=2'b01, taken=1 -> next-cycle bp_predict=2'b10.
REQ-024 if_stall=1 for 3 cycles while if_pc changes -> bp_predict constant.
REQ-025 init_req pulse with simultaneous update to 0x300 -> bp_ready=0 next cycle, after 1024 cycles entry for 0x300 reads 2'b01.
REQ-026 rstn asserted at sweep=500 -> outputs 2'b00/0 immediately; full 1024-cycle sweep follows release.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// riscv_pkg -- shared 2-bit saturating counter encodings and update helper. Rev 1.0
package riscv_pkg;

  localparam logic [1:0] C_CNT_SNT = 2'b00;
  localparam logic [1:0] C_CNT_WNT = 2'b01;
  localparam logic [1:0] C_CNT_WT  = 2'b10;
  localparam logic [1:0] C_CNT_ST  = 2'b11;

  function automatic logic [1:0] bp_cnt_next(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == C_CNT_ST)  ? C_CNT_ST  : cnt + 2'b01;
    else       return (cnt == C_CNT_SNT) ? C_CNT_SNT : cnt - 2'b01;
  endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_state_pkg.sv
`default_nettype none
// riscv_state_pkg -- branch predictor controller FSM states and table init value. Rev 1.0
package riscv_state_pkg;
  import riscv_pkg::*;

  typedef enum logic [0:0] {
    BP_INIT = 1'b0,
    BP_RUN  = 1'b1
  } bp_state_e;

  localparam logic [1:0] C_BP_INIT_CNT = C_CNT_WNT;

endpackage
`default_nettype wire

// File: rtl/riscv_bp_ram.sv
`default_nettype none
// riscv_bp_ram -- 1R1W counter table, registered read, write-first on address collision. Rev 1.0
module riscv_bp_ram #(
  parameter int AW = 10,
  parameter int DW = 2
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/riscv_bp_ctrl.sv
`default_nettype none
// riscv_bp_ctrl -- history+PC indexed 2-bit branch predictor with init sweep FSM. Rev 1.0
module riscv_bp_ctrl
  import riscv_pkg::*;
  import riscv_state_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BP_GLOBAL_BITS = 2,
  parameter int BP_LOCAL_BITS  = 8,
  parameter int HAS_RVC        = 0
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      if_stall,
  input  logic [XLEN-1:0]           if_pc,
  output logic [1:0]                bp_predict,
  output logic                      bp_ready,
  input  logic                      init_req,
  input  logic                      bu_bp_update,
  input  logic                      bu_bp_btaken,
  input  logic [1:0]                bu_bp_predict,
  input  logic [BP_GLOBAL_BITS-1:0] bu_bp_history,
  input  logic [XLEN-1:0]           bu_pc
);

  localparam int IW    = BP_GLOBAL_BITS + BP_LOCAL_BITS;
  localparam int SW    = IW + 1;
  localparam int S     = (HAS_RVC != 0) ? 1 : 2;
  localparam int DEPTH = 1 << IW;
  localparam logic [SW-1:0] C_LAST = SW'(DEPTH - 1);

  bp_state_e         r_state, w_state_nxt;
  logic [SW-1:0]     r_sweep, w_sweep_nxt;
  logic              r_ready, w_ready_nxt;
  logic              r_pvld, w_pvld_nxt;
  logic              w_we, w_re;
  logic [IW-1:0]     w_waddr, w_lkp_idx, w_upd_idx;
  logic [1:0]        w_wdata, w_rdata;
  logic              w_unused_pc;

  // Upper PC bits alias freely; only the index window is significant.
  assign w_lkp_idx   = {bu_bp_history, if_pc[BP_LOCAL_BITS+S-1:S]};
  assign w_upd_idx   = {bu_bp_history, bu_pc[BP_LOCAL_BITS+S-1:S]};
  assign w_unused_pc = ^{if_pc, bu_pc};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= BP_INIT;
      r_sweep <= '0;
      r_ready <= 1'b0;
      r_pvld  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sweep <= w_sweep_nxt;
      r_ready <= w_ready_nxt;
      r_pvld  <= w_pvld_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sweep_nxt = r_sweep;
    w_ready_nxt = r_ready;
    w_pvld_nxt  = r_pvld;
    w_we        = 1'b0;
    w_re        = 1'b0;
    w_waddr     = w_upd_idx;
    w_wdata     = bp_cnt_next(bu_bp_predict, bu_bp_btaken);
    case (r_state)
      BP_INIT: begin
        w_we        = 1'b1;
        w_waddr     = r_sweep[IW-1:0];
        w_wdata     = C_BP_INIT_CNT;
        w_ready_nxt = 1'b0;
        w_pvld_nxt  = 1'b0;
        if (init_req) begin
          w_sweep_nxt = '0;
        end else if (r_sweep == C_LAST) begin
          w_state_nxt = BP_RUN;
          w_sweep_nxt = r_sweep + 1'b1;
          w_ready_nxt = 1'b1;
        end else begin
          w_sweep_nxt = r_sweep + 1'b1;
        end
      end
      BP_RUN: begin
        if (init_req) begin
          // Re-initialisation takes priority; a coincident update is discarded.
          w_state_nxt = BP_INIT;
          w_sweep_nxt = '0;
          w_ready_nxt = 1'b0;
          w_pvld_nxt  = 1'b0;
        end else begin
          w_we = bu_bp_update;
          if (!if_stall) begin
            w_re       = 1'b1;
            w_pvld_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = BP_INIT;
    endcase
  end

  riscv_bp_ram #(
    .AW (IW),
    .DW (2)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .i_raddr (w_lkp_idx),
    .o_rdata (w_rdata)
  );

  // RAM output has no reset; the valid flag masks it to 00 outside RUN.
  assign bp_predict = r_pvld ? w_rdata : C_CNT_SNT;
  assign bp_ready   = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_riscv_bp_ctrl.sv
`default_nettype none
// tb_riscv_bp_ctrl -- vector table + scoreboard bench for riscv_bp_ctrl. Rev 1.0
module tb_riscv_bp_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        if_stall = 1'b0;
  logic [31:0] if_pc = '0;
  logic [1:0]  bp_predict;
  logic        bp_ready;
  logic        init_req = 1'b0;
  logic        bu_bp_update = 1'b0;
  logic        bu_bp_btaken = 1'b0;
  logic [1:0]  bu_bp_predict = '0;
  logic [1:0]  bu_bp_history = '0;
  logic [31:0] bu_pc = '0;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic        stall;
    logic [31:0] pc;
    logic [1:0]  hist;
    logic        upd;
    logic        tkn;
    logic [1:0]  bpred;
    logic [31:0] bupc;
    logic [1:0]  exp;
  } vec_t;

  vec_t       vecs [19];
  logic [1:0] exp_q [$];

  always #5 clk = ~clk;

  riscv_bp_ctrl #(
    .XLEN           (32),
    .BP_GLOBAL_BITS (2),
    .BP_LOCAL_BITS  (8),
    .HAS_RVC        (0)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .if_stall      (if_stall),
    .if_pc         (if_pc),
    .bp_predict    (bp_predict),
    .bp_ready      (bp_ready),
    .init_req      (init_req),
    .bu_bp_update  (bu_bp_update),
    .bu_bp_btaken  (bu_bp_btaken),
    .bu_bp_predict (bu_bp_predict),
    .bu_bp_history (bu_bp_history),
    .bu_pc         (bu_pc)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic st, input logic [31:0] pc, input logic [1:0] h,
                               input logic u, input logic t, input logic [1:0] bp,
                               input logic [31:0] bpc, input logic [1:0] e);
    vec_t v;
    v.stall = st; v.pc = pc; v.hist = h; v.upd = u; v.tkn = t;
    v.bpred = bp; v.bupc = bpc; v.exp = e;
    return v;
  endfunction

  // Drive one cycle of stimulus, queue the expected prediction, compare after the edge.
  task automatic drive(input vec_t v, input string nm);
    logic [1:0] e;
    if_stall      = v.stall;
    if_pc         = v.pc;
    bu_bp_history = v.hist;
    bu_bp_update  = v.upd;
    bu_bp_btaken  = v.tkn;
    bu_bp_predict = v.bpred;
    bu_pc         = v.bupc;
    exp_q.push_back(v.exp);
    @(posedge clk); #1;
    if (exp_q.size() == 0) begin
      chk({nm, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk(nm, {30'd0, bp_predict}, {30'd0, e});
    end
    bu_bp_update = 1'b0;
    if_stall     = 1'b0;
  endtask

  // Count rising edges until bp_ready is seen, bounded.
  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (cnt < 1100) begin
      @(posedge clk); #1;
      cnt++;
      if (cnt == 512) chk("init_predict_zero", {30'd0, bp_predict}, 32'd0);
      if (bp_ready) break;
    end
  endtask

  initial begin
    int cnt;

    vecs[0]  = mkv(0, 32'h0000_0100, 2'd0, 0, 0, 2'b00, 32'h0,         2'b01);
    vecs[1]  = mkv(0, 32'h0000_03FC, 2'd3, 0, 0, 2'b00, 32'h0,         2'b01);
    vecs[2]  = mkv(0, 32'h0000_0000, 2'd0, 1, 1, 2'b11, 32'h0000_0100, 2'b01);
    vecs[3]  = mkv(0, 32'h0000_0100, 2'd0, 0, 0, 2'b00, 32'h0,         2'b11);
    vecs[4]  = mkv(0, 32'h0000_0104, 2'd0, 1, 0, 2'b01, 32'h0000_0100, 2'b01);
    vecs[5]  = mkv(0, 32'h0000_0100, 2'd0, 0, 0, 2'b00, 32'h0,         2'b00);
    vecs[6]  = mkv(0, 32'h0000_0204, 2'd2, 1, 1, 2'b01, 32'h0000_0204, 2'b10);
    vecs[7]  = mkv(0, 32'h0000_0204, 2'd2, 0, 0, 2'b00, 32'h0,         2'b10);
    vecs[8]  = mkv(0, 32'h8000_0100, 2'd0, 0, 0, 2'b00, 32'h0,         2'b00);
    vecs[9]  = mkv(0, 32'h0000_0102, 2'd0, 0, 0, 2'b00, 32'h0,         2'b00);
    vecs[10] = mkv(0, 32'h0000_0104, 2'd0, 1, 0, 2'b00, 32'h0000_0104, 2'b00);
    vecs[11] = mkv(0, 32'h0000_010C, 2'd1, 1, 1, 2'b10, 32'h0000_0108, 2'b01);
    vecs[12] = mkv(0, 32'h0000_0108, 2'd1, 0, 0, 2'b00, 32'h0,         2'b11);
    vecs[13] = mkv(1, 32'h0000_0100, 2'd0, 0, 0, 2'b00, 32'h0,         2'b11);
    vecs[14] = mkv(1, 32'h0000_0204, 2'd2, 0, 0, 2'b00, 32'h0,         2'b11);
    vecs[15] = mkv(1, 32'h0000_03FC, 2'd3, 0, 0, 2'b00, 32'h0,         2'b11);
    vecs[16] = mkv(0, 32'h0000_0108, 2'd0, 0, 0, 2'b00, 32'h0,         2'b01);
    vecs[17] = mkv(1, 32'h0000_0204, 2'd2, 1, 0, 2'b10, 32'h0000_0204, 2'b01);
    vecs[18] = mkv(0, 32'h0000_0204, 2'd2, 0, 0, 2'b00, 32'h0,         2'b01);

    #1;
    chk("reset_predict", {30'd0, bp_predict}, 32'd0);
    chk("reset_ready",   {31'd0, bp_ready},   32'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    wait_ready(cnt);
    chk("ready_latency", cnt, 32'd1024);

    for (int i = 0; i < 19; i++) drive(vecs[i], $sformatf("vec%0d", i));

    // Re-initialisation with a coincident (dropped) update.
    drive(mkv(0, 32'h300, 2'd0, 1, 1, 2'b10, 32'h300, 2'b11), "pre300_fwd");
    drive(mkv(0, 32'h300, 2'd0, 0, 0, 2'b00, 32'h0,   2'b11), "pre300_rd");
    init_req = 1'b1; bu_bp_update = 1'b1; bu_pc = 32'h300; bu_bp_history = 2'd0;
    bu_bp_predict = 2'b11; bu_bp_btaken = 1'b1; if_pc = 32'h300;
    @(posedge clk); #1;
    chk("initreq_ready", {31'd0, bp_ready},   32'd0);
    chk("initreq_pred",  {30'd0, bp_predict}, 32'd0);
    init_req = 1'b0;
    bu_bp_predict = 2'b10;
    wait_ready(cnt);
    bu_bp_update = 1'b0;
    chk("reinit_latency", cnt, 32'd1024);
    drive(mkv(0, 32'h300, 2'd0, 0, 0, 2'b00, 32'h0, 2'b01), "post300_rd");
    drive(mkv(0, 32'h100, 2'd0, 0, 0, 2'b00, 32'h0, 2'b01), "post100_rd");

    // Asynchronous reset in RUN and again part-way through the sweep.
    #3 rstn = 1'b0;
    #1;
    chk("run_rst_pred",  {30'd0, bp_predict}, 32'd0);
    chk("run_rst_ready", {31'd0, bp_ready},   32'd0);
    @(posedge clk); #1 rstn = 1'b1;
    repeat (500) @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    chk("mid_rst_pred",  {30'd0, bp_predict}, 32'd0);
    chk("mid_rst_ready", {31'd0, bp_ready},   32'd0);
    @(posedge clk); #1 rstn = 1'b1;
    wait_ready(cnt);
    chk("rst_sweep_latency", cnt, 32'd1024);
    drive(mkv(0, 32'h108, 2'd1, 0, 0, 2'b00, 32'h0, 2'b01), "final_rd");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
